// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM state type and duty-width helper for the PWM generator.
package pwm_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_e;
   function automatic int duty_w(input int width);
      return width + 1;
   endfunction
endpackage

// File: rtl/pwm_wrap_det.sv
// pwm_wrap_det: registers the counter value and flags the first cycle it returns to zero.
module pwm_wrap_det #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] cnt_i,
   output logic             wrap_o
);
   logic [WIDTH-1:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d  = cnt_i;
      wrap_o = (cnt_i == '0) && (cnt_q != '0);
   end
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: compares an external counter against a wrap-synchronised duty setting and
// drives a registered PWM output with period-aligned start/stop.
module pwm_gen
   import pwm_pkg::*;
#(
   parameter int   WIDTH = 4,
   parameter logic POL   = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [WIDTH-1:0]      cnt_i,
   input  logic                  en_i,
   input  logic [duty_w(WIDTH)-1:0] duty_i,
   input  logic                  duty_valid_i,
   output logic                  duty_ready_o,
   output logic                  pwm_o,
   output logic                  period_o,
   output logic                  busy_o
);
   localparam int DW = duty_w(WIDTH);
   state_e        state_q, state_d;
   logic [DW-1:0] duty_act_q, duty_act_d, shadow_q, shadow_d, duty_eff;
   logic          shadow_full_q, shadow_full_d, pwm_q, pwm_d, period_q, period_d;
   logic          wrap, accept, active, load_shadow;
   pwm_wrap_det #(.WIDTH(WIDTH)) u_wrap_det (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .cnt_i   (cnt_i),
      .wrap_o  (wrap)
   );
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = en_i ? ARM : IDLE;
         ARM:     state_d = !en_i ? IDLE : wrap ? RUN : ARM;
         RUN:     state_d = en_i ? RUN : DRAIN;
         DRAIN:   state_d = en_i ? RUN : wrap ? IDLE : DRAIN;
         default: state_d = IDLE;
      endcase
   end
   // The pending shadow value governs the very first compare of the period it opens.
   always_comb begin
      accept        = duty_valid_i && !shadow_full_q;
      load_shadow   = accept && (state_q != IDLE);
      duty_eff      = (wrap && shadow_full_q) ? shadow_q : duty_act_q;
      active        = (state_d == RUN || state_d == DRAIN) && ({1'b0, cnt_i} < duty_eff);
      pwm_d         = active ? POL : ~POL;
      period_d      = wrap && (state_d == RUN);
      duty_act_d    = (accept && state_q == IDLE) ? duty_i :
                      (wrap && shadow_full_q) ? shadow_q : duty_act_q;
      shadow_d      = load_shadow ? duty_i : shadow_q;
      shadow_full_d = load_shadow ? 1'b1 : wrap ? 1'b0 : shadow_full_q;
   end
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         duty_act_q    <= '0;
         shadow_q      <= '0;
         shadow_full_q <= 1'b0;
         pwm_q         <= ~POL;
         period_q      <= 1'b0;
      end else begin
         duty_act_q    <= duty_act_d;
         shadow_q      <= shadow_d;
         shadow_full_q <= shadow_full_d;
         pwm_q         <= pwm_d;
         period_q      <= period_d;
      end
   assign duty_ready_o = !shadow_full_q;
   assign pwm_o        = pwm_q;
   assign period_o     = period_q;
   assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed checks of pwm_gen driven by a local free-running 4-bit counter.
module tb_pwm_gen;
   logic       clk_i = 1'b0, reset_i = 1'b1, en_i = 1'b0, duty_valid_i = 1'b0, cnt_clr = 1'b0;
   logic [3:0] cnt;
   logic [4:0] duty_i = '0;
   logic       duty_ready_o, pwm_o, period_o, busy_o;
   int         n_chk = 0, n_fail = 0;
   pwm_gen #(.WIDTH(4), .POL(1'b1)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .cnt_i        (cnt),
      .en_i         (en_i),
      .duty_i       (duty_i),
      .duty_valid_i (duty_valid_i),
      .duty_ready_o (duty_ready_o),
      .pwm_o        (pwm_o),
      .period_o     (period_o),
      .busy_o       (busy_o)
   );
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i or posedge reset_i)
      if (reset_i || cnt_clr) cnt <= '0;
      else                    cnt <= cnt + 4'd1;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask
   task automatic wait_cnt(input logic [3:0] v);
      int k = 0;
      while (cnt != v && k < 40) begin
         @(negedge clk_i);
         k++;
      end
      check("wait_cnt", cnt, v);
   endtask
   task automatic push(input logic [4:0] d);
      duty_i       = d;
      duty_valid_i = 1'b1;
      @(negedge clk_i);
      duty_valid_i = 1'b0;
   endtask
   // Output for count c is visible once the counter shows c+1.
   task automatic run_period(input string tag, input int duty);
      wait_cnt(4'd0);
      @(negedge clk_i);
      for (int i = 0; i < 16; i++) begin
         check({tag, "_pwm"}, pwm_o, (i < duty) ? 1 : 0);
         check({tag, "_period"}, period_o, (i == 0) ? 1 : 0);
         @(negedge clk_i);
      end
   endtask
   initial begin
      repeat (3) @(negedge clk_i);
      check("rst_pwm", pwm_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_ready", duty_ready_o, 1);
      check("rst_period", period_o, 0);
      reset_i = 1'b0;
      en_i    = 1'b1;
      push(5'd6);
      check("t1_busy_arm", busy_o, 1);
      check("t1_pwm_arm", pwm_o, 0);
      check("t1_ready_idle", duty_ready_o, 1);
      run_period("t1a", 6);
      run_period("t1b", 6);
      push(5'd0);
      check("t2_ready_full", duty_ready_o, 0);
      run_period("t2_zero", 0);
      check("t2_ready_back", duty_ready_o, 1);
      push(5'd16);
      run_period("t2_full", 16);
      push(5'd6);
      run_period("t3_six", 6);
      wait_cnt(4'd3);
      push(5'd12);
      check("t3_ready_drop", duty_ready_o, 0);
      while (cnt != 4'd0) begin
         check("t3_keep6", pwm_o, ((int'(cnt) - 1) < 6) ? 1 : 0);
         @(negedge clk_i);
      end
      run_period("t3_twelve", 12);
      check("t3_ready_back", duty_ready_o, 1);
      wait_cnt(4'd3);
      en_i = 1'b0;
      @(negedge clk_i);
      check("t4_busy_drain", busy_o, 1);
      while (cnt != 4'd0) begin
         check("t4_drain_pwm", pwm_o, ((int'(cnt) - 1) < 12) ? 1 : 0);
         @(negedge clk_i);
      end
      @(negedge clk_i);
      check("t4_idle_busy", busy_o, 0);
      check("t4_idle_pwm", pwm_o, 0);
      check("t4_idle_period", period_o, 0);
      repeat (3) @(negedge clk_i);
      check("t4_idle_pwm2", pwm_o, 0);
      en_i = 1'b1;
      run_period("t5a", 12);
      wait_cnt(4'd9);
      cnt_clr = 1'b1;
      @(negedge clk_i);
      cnt_clr = 1'b0;
      check("t5_pwm_at9", pwm_o, 1);
      run_period("t5b", 12);
      wait_cnt(4'd5);
      cnt_clr = 1'b1;
      @(negedge clk_i);
      check("t5_hold_p0", period_o, 0);
      @(negedge clk_i);
      check("t5_hold_p1", period_o, 1);
      check("t5_hold_pwm", pwm_o, 1);
      @(negedge clk_i);
      check("t5_hold_once", period_o, 0);
      cnt_clr = 1'b0;
      wait_cnt(4'd3);
      push(5'd6);
      check("t6_ready_full", duty_ready_o, 0);
      check("t6_pwm_pre", pwm_o, 1);
      check("t6_busy_pre", busy_o, 1);
      #2 reset_i = 1'b1;
      #1;
      check("t6_pwm", pwm_o, 0);
      check("t6_busy", busy_o, 0);
      check("t6_ready", duty_ready_o, 1);
      check("t6_period", period_o, 0);
      @(negedge clk_i);
      reset_i = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
